// File: rtl/pmp_check_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmp_check_sequencer_pkg
//  Description : Shared encodings for the sequential PMP checker: cfg field
//                positions, A-field modes, request types, FSM states and
//                exception codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pmp_check_sequencer_pkg;

  // XLEN width encodings; address width is 1 << (XLEN + 4)
  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;

  // pmpcfg byte field positions
  localparam int PMP_CFG_R    = 0;
  localparam int PMP_CFG_W    = 1;
  localparam int PMP_CFG_X    = 2;
  localparam int PMP_CFG_A_LO = 3;
  localparam int PMP_CFG_A_HI = 4;
  localparam int PMP_CFG_L    = 7;

  // Address-matching modes held in the A field
  localparam logic [1:0] PMP_OFF   = 2'b00;
  localparam logic [1:0] PMP_TOR   = 2'b01;
  localparam logic [1:0] PMP_NA4   = 2'b10;
  localparam logic [1:0] PMP_NAPOT = 2'b11;

  // Request types; the reserved encoding behaves as a load
  localparam logic [1:0] REQ_FETCH = 2'b00;
  localparam logic [1:0] REQ_LOAD  = 2'b01;
  localparam logic [1:0] REQ_STORE = 2'b10;
  localparam logic [1:0] REQ_RSVD  = 2'b11;

  localparam logic [1:0] PRIV_M = 2'b11;

  // Exception codes shared with the pipeline exception logic
  localparam logic [3:0] NO_E                 = 4'd0;
  localparam logic [3:0] E_ILLEGAL_INSTR      = 4'd2;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] E_STORE_ACCESS_FAULT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Exception raised when an access of the given type is denied
  function automatic logic [3:0] pmp_fault_code(input logic [1:0] req_type);
    logic [3:0] code;
    case (req_type)
      REQ_FETCH: code = E_ILLEGAL_INSTR;
      REQ_STORE: code = E_STORE_ACCESS_FAULT;
      default:   code = E_LOAD_ACCESS_FAULT;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmp_check_sequencer_entry_match.sv
`default_nettype none
// ============================================================================
//  Module      : pmp_entry_match
//  Description : Combinational match of one PMP entry against an address,
//                plus the R/W/X permission bit for the request type.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmp_entry_match
  import pmp_check_sequencer_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_cur,
  input  logic [AW-1:0] i_prev,
  input  logic [7:0]    i_cfg,
  input  logic [1:0]    i_req_type,
  output logic          o_hit,
  output logic          o_perm_ok
);

  logic [AW-1:0] w_cur_s;
  logic [AW-1:0] w_prev_s;
  logic [AW-1:0] w_na4_end;
  logic [AW-1:0] w_napot_mask;
  logic [7:0]    w_tone;
  logic          w_run;
  logic          w_tor_hit;
  logic          w_na4_hit;
  logic          w_napot_hit;
  logic          w_unused_cfg;

  // L is consumed by the sequencer; bits 6:5 are reserved
  assign w_unused_cfg = ^i_cfg[7:5];

  assign w_cur_s   = i_cur << 2;
  assign w_prev_s  = i_prev << 2;
  assign w_na4_end = w_cur_s + AW'(4);

  // Count trailing ones of pmpaddr to size the NAPOT region
  always_comb begin
    w_tone = '0;
    w_run  = 1'b1;
    for (int i = 0; i < AW; i++) begin
      if (w_run && i_cur[i]) begin
        w_tone = w_tone + 8'd1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Region is aligned to 2^(t+3): only address bits at or above t+3 compare;
  // a region at least as large as the address space matches everything
  always_comb begin
    w_napot_mask = '0;
    for (int i = 0; i < AW; i++) begin
      w_napot_mask[i] = (9'(i) >= ({1'b0, w_tone} + 9'd3));
    end
  end

  assign w_tor_hit   = (i_prev < i_cur) && (i_addr >= w_prev_s) && (i_addr < w_cur_s);
  assign w_na4_hit   = (i_addr >= w_cur_s) && (i_addr < w_na4_end);
  assign w_napot_hit = (((i_addr ^ w_cur_s) & w_napot_mask) == '0);

  // Select the matcher chosen by the A field
  always_comb begin
    case (i_cfg[PMP_CFG_A_HI:PMP_CFG_A_LO])
      PMP_TOR:   o_hit = w_tor_hit;
      PMP_NA4:   o_hit = w_na4_hit;
      PMP_NAPOT: o_hit = w_napot_hit;
      default:   o_hit = 1'b0;
    endcase
  end

  // Permission bit relevant to this access type
  always_comb begin
    case (i_req_type)
      REQ_FETCH: o_perm_ok = i_cfg[PMP_CFG_X];
      REQ_STORE: o_perm_ok = i_cfg[PMP_CFG_W];
      default:   o_perm_ok = i_cfg[PMP_CFG_R];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pmp_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pmp_check_sequencer
//  Description : Multi-cycle PMP checker. Scans one pmpaddr/pmpcfg entry per
//                cycle in priority order and returns an exception code over a
//                valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmp_check_sequencer
  import pmp_check_sequencer_pkg::*;
#(
  parameter  int XLEN                  = XLEN_64B,
  parameter  int ENABLED_PMP_REGISTERS = 12,
  localparam int AW                    = 1 << (XLEN + 4)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [AW-1:0]    i_req_addr,
  input  logic [1:0]       i_req_type,
  input  logic [1:0]       i_req_priv,
  input  logic             i_flush,
  input  logic             i_cfg_dirty,
  input  logic [AW*64-1:0] i_concat_pmpaddr,
  input  logic [511:0]     i_concat_pmpcfg,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [3:0]       o_rsp_code,
  output logic             o_rsp_hit,
  output logic [5:0]       o_rsp_idx
);

  localparam logic [5:0] C_LAST_IDX = 6'(ENABLED_PMP_REGISTERS - 1);

  seq_state_e    r_state;
  logic [5:0]    r_idx;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_type;
  logic [1:0]    r_priv;

  logic [5:0]    w_prev_idx;
  logic [AW-1:0] w_cur;
  logic [AW-1:0] w_prev;
  logic [7:0]    w_cfg;
  logic          w_locked;
  logic          w_hit;
  logic          w_perm_ok;
  logic [3:0]    w_fault;
  logic [3:0]    w_code;

  // Index mux over the live CSR outputs; entry 0 has an implicit prev of 0
  assign w_prev_idx = r_idx - 6'd1;
  assign w_cur      = i_concat_pmpaddr[r_idx*AW +: AW];
  assign w_prev     = (r_idx == 6'd0) ? '0 : i_concat_pmpaddr[w_prev_idx*AW +: AW];
  assign w_cfg      = i_concat_pmpcfg[r_idx*8 +: 8];
  assign w_locked   = w_cfg[PMP_CFG_L];

  pmp_entry_match #(
    .AW (AW)
  ) u_entry_match (
    .i_addr     (r_addr),
    .i_cur      (w_cur),
    .i_prev     (w_prev),
    .i_cfg      (w_cfg),
    .i_req_type (r_type),
    .o_hit      (w_hit),
    .o_perm_ok  (w_perm_ok)
  );

  // Resolve the exception for the entry under evaluation; an unlocked entry
  // never restricts M-mode, and M-mode passes when nothing matches
  always_comb begin
    w_fault = pmp_fault_code(r_type);
    if (w_hit) begin
      if ((r_priv == PRIV_M) && !w_locked) begin
        w_code = NO_E;
      end else begin
        w_code = w_perm_ok ? NO_E : w_fault;
      end
    end else begin
      w_code = (r_priv == PRIV_M) ? NO_E : w_fault;
    end
  end

  // Sequencer FSM: request latch, entry index and registered response
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_type      <= REQ_FETCH;
      r_priv      <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_code  <= NO_E;
      o_rsp_hit   <= 1'b0;
      o_rsp_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_req_ready <= 1'b1;
          if (i_req_valid && !i_flush) begin
            r_addr      <= i_req_addr;
            r_type      <= i_req_type;
            r_priv      <= i_req_priv;
            r_idx       <= '0;
            o_req_ready <= 1'b0;
            r_state     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (i_flush) begin
            r_state     <= ST_IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
          end else if (i_cfg_dirty) begin
            // Config changed under us: restart from the highest-priority entry
            r_idx <= '0;
          end else if (w_hit || (r_idx == C_LAST_IDX)) begin
            o_rsp_valid <= 1'b1;
            o_rsp_code  <= w_code;
            o_rsp_hit   <= w_hit;
            o_rsp_idx   <= w_hit ? r_idx : 6'd0;
            r_state     <= ST_RESP;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end

        ST_RESP: begin
          if (i_flush || i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmp_check_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmp_check_sequencer
//  Description : Self-checking bench for pmp_check_sequencer using an
//                expected-response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmp_check_sequencer;

  localparam int AW = 64;
  localparam int N  = 12;

  logic             clk;
  logic             rst;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [AW-1:0]    i_req_addr;
  logic [1:0]       i_req_type;
  logic [1:0]       i_req_priv;
  logic             i_flush;
  logic             i_cfg_dirty;
  logic [AW*64-1:0] i_concat_pmpaddr;
  logic [511:0]     i_concat_pmpcfg;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [3:0]       o_rsp_code;
  logic             o_rsp_hit;
  logic [5:0]       o_rsp_idx;

  logic [AW-1:0] pa [64];
  logic [7:0]    pc [64];

  typedef struct {
    logic [3:0] code;
    logic       hit;
    logic [5:0] idx;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  pmp_check_sequencer #(
    .XLEN                  (2),
    .ENABLED_PMP_REGISTERS (N)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_addr       (i_req_addr),
    .i_req_type       (i_req_type),
    .i_req_priv       (i_req_priv),
    .i_flush          (i_flush),
    .i_cfg_dirty      (i_cfg_dirty),
    .i_concat_pmpaddr (i_concat_pmpaddr),
    .i_concat_pmpcfg  (i_concat_pmpcfg),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_code       (o_rsp_code),
    .o_rsp_hit        (o_rsp_hit),
    .o_rsp_idx        (o_rsp_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-entry arrays into the CSR-file bus layout
  always_comb begin
    i_concat_pmpaddr = '0;
    i_concat_pmpcfg  = '0;
    for (int i = 0; i < 64; i++) begin
      i_concat_pmpaddr[i*AW +: AW] = pa[i];
      i_concat_pmpcfg[i*8 +: 8]    = pc[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 64; i++) begin
      pa[i] = '0;
      pc[i] = '0;
    end
  endtask

  task automatic push_exp(input logic [3:0] code, input logic hit, input logic [5:0] idx, input int lat);
    exp_t e;
    e.code = code;
    e.hit  = hit;
    e.idx  = idx;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic [63:0] addr, input logic [1:0] typ, input logic [1:0] priv);
    @(negedge clk);
    for (int w = 0; w < 50 && !o_req_ready; w++) @(negedge clk);
    chk("ready_before_req", {63'd0, o_req_ready}, 64'd1);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    i_req_type  = typ;
    i_req_priv  = priv;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    chk("ready_low_scan", {63'd0, o_req_ready}, 64'd0);
  endtask

  // Issue one request; cycle 0 is the accept cycle, so cyc counts cycles
  // after it. Optionally pulse i_cfg_dirty in one cycle and hold the
  // response un-acknowledged for a number of cycles.
  task automatic run_req(input logic [63:0] addr, input logic [1:0] typ, input logic [1:0] priv,
                         input int dirty_cyc, input int hold);
    int   cyc;
    exp_t e;
    drive_req(addr, typ, priv);
    cyc = 1;
    while (cyc < 200) begin
      i_cfg_dirty = (cyc == dirty_cyc);
      if (o_rsp_valid) break;
      @(negedge clk);
      cyc++;
    end
    i_cfg_dirty = 1'b0;
    if (!o_rsp_valid) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("rsp_code", {60'd0, o_rsp_code}, {60'd0, e.code});
    chk("rsp_hit",  {63'd0, o_rsp_hit},  {63'd0, e.hit});
    chk("rsp_idx",  {58'd0, o_rsp_idx},  {58'd0, e.idx});
    chk("rsp_lat",  64'(cyc),            64'(e.lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
      chk("hold_code",  {60'd0, o_rsp_code},  {60'd0, e.code});
      chk("hold_idx",   {58'd0, o_rsp_idx},   {58'd0, e.idx});
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk("valid_dropped", {63'd0, o_rsp_valid}, 64'd0);
    chk("ready_returned", {63'd0, o_req_ready}, 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, o_req_ready}, 64'd1);
    chk({tag, "_valid"}, {63'd0, o_rsp_valid}, 64'd0);
    chk({tag, "_code"},  {60'd0, o_rsp_code},  64'd0);
    chk({tag, "_hit"},   {63'd0, o_rsp_hit},   64'd0);
    chk({tag, "_idx"},   {58'd0, o_rsp_idx},   64'd0);
  endtask

  initial begin
    int seen;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_req_type  = 2'b00;
    i_req_priv  = 2'b00;
    i_flush     = 1'b0;
    i_cfg_dirty = 1'b0;
    i_rsp_ready = 1'b0;
    clear_cfg();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Load, U-mode, entry0 TOR [0,0x2000) with R
    pa[0] = 64'h800; pc[0] = 8'h09;
    push_exp(4'd0, 1'b1, 6'd0, 2);
    run_req(64'h1000, 2'b01, 2'b00, 0, 0);

    // Reserved type behaves as load: W-only entry denies it
    pc[0] = 8'h0A;
    push_exp(4'd5, 1'b1, 6'd0, 2);
    run_req(64'h100, 2'b11, 2'b00, 0, 0);

    // Store, S-mode, entry3 NA4 at 0x2004 with R only
    clear_cfg();
    pa[3] = 64'h801; pc[3] = 8'h11;
    push_exp(4'd7, 1'b1, 6'd3, 5);
    run_req(64'h2004, 2'b10, 2'b01, 0, 0);

    // Fetch, M-mode, entry1 NAPOT [0x4000,0x8000) locked without X
    clear_cfg();
    pa[1] = 64'h17FF; pc[1] = 8'h98;
    push_exp(4'd2, 1'b1, 6'd1, 3);
    run_req(64'h4000, 2'b00, 2'b11, 0, 0);
    // Same entry unlocked: M-mode is not restricted
    pc[1] = 8'h18;
    push_exp(4'd0, 1'b1, 6'd1, 3);
    run_req(64'h4000, 2'b00, 2'b11, 0, 0);
    // Just past the NAPOT region: no entry matches, U-mode fetch faults
    pc[1] = 8'h1C;
    push_exp(4'd2, 1'b0, 6'd0, N + 1);
    run_req(64'h8000, 2'b00, 2'b00, 0, 0);

    // All entries OFF: U-mode load faults at worst-case latency, M passes
    clear_cfg();
    push_exp(4'd5, 1'b0, 6'd0, N + 1);
    run_req(64'h9000, 2'b01, 2'b00, 0, 0);
    push_exp(4'd0, 1'b0, 6'd0, N + 1);
    run_req(64'h9000, 2'b01, 2'b11, 0, 0);

    // TOR bounded below by the previous entry: [0x1000,0x2000)
    pa[0] = 64'h400; pa[1] = 64'h800; pc[1] = 8'h0F;
    push_exp(4'd0, 1'b1, 6'd1, 3);
    run_req(64'h1800, 2'b10, 2'b00, 0, 0);
    push_exp(4'd7, 1'b0, 6'd0, N + 1);
    run_req(64'hFFC, 2'b10, 2'b00, 0, 0);

    // All-ones NAPOT covers the whole address space
    clear_cfg();
    pa[2] = '1; pc[2] = 8'h1F;
    push_exp(4'd0, 1'b1, 6'd2, 4);
    run_req(64'hFFFF_0000_0000_0000, 2'b01, 2'b00, 0, 0);

    // cfg_dirty while index 5 is evaluated (cycle 6): restart at 0, so the
    // entry7 hit lands at cycle 15 instead of 9
    clear_cfg();
    pa[7] = 64'hC00; pc[7] = 8'h13;
    push_exp(4'd0, 1'b1, 6'd7, 15);
    run_req(64'h3000, 2'b01, 2'b00, 6, 0);

    // Flush in the cycle entry0 would match: no response, back to IDLE
    clear_cfg();
    pa[0] = 64'h800; pc[0] = 8'h09;
    drive_req(64'h1000, 2'b01, 2'b00);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_ready", {63'd0, o_req_ready}, 64'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_rsp_valid) seen++;
      @(negedge clk);
    end
    chk("flush_no_rsp", 64'(seen), 64'd0);

    // Request coinciding with flush in IDLE is not accepted
    i_req_valid = 1'b1;
    i_req_addr  = 64'h1000;
    i_req_type  = 2'b01;
    i_flush     = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_flush     = 1'b0;
    chk("idle_flush_reject", {63'd0, o_req_ready}, 64'd1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_rsp_valid) seen++;
      @(negedge clk);
    end
    chk("idle_flush_no_rsp", 64'(seen), 64'd0);

    // Response held for 4 cycles must stay stable
    push_exp(4'd0, 1'b1, 6'd0, 2);
    run_req(64'h1000, 2'b01, 2'b00, 0, 4);

    // Asynchronous reset mid-scan clears everything immediately
    clear_cfg();
    drive_req(64'h9000, 2'b01, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pmp_check_sequencer.md
Name: pmp_check_sequencer

Overview:
- Multi-cycle PMP permission checker that sequences one pmpaddr/pmpcfg entry per cycle and replaces a wide parallel compare.
- Accepts one access request (fetch, load or store) through a valid/ready handshake.
- Scans entries 0..ENABLED_PMP_REGISTERS-1 in priority order, stops at the first match, and returns an exception code through a valid/ready response.
- Sits between the pipeline exception logic and the CSR file's concatenated PMP outputs.

Parameters:
- XLEN, `XLEN_64b, width encoding; address width AW = 1<<(XLEN+4).
- ENABLED_PMP_REGISTERS, 12, number of entries scanned (1..64).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  block can accept a request
- i_req_addr  in  AW  byte address (PC or ALU result)
- i_req_type  in  2  00 fetch/exec, 01 load, 10 store, 11 reserved (treated as load)
- i_req_priv  in  2  current privilege
- i_flush  in  1  abort the in-flight check
- i_cfg_dirty  in  1  a pmpcfg/pmpaddr CSR write commits this cycle
- i_concat_pmpaddr  in  AW*64  entry i at bits [(i+1)*AW-1 : i*AW]
- i_concat_pmpcfg  in  512  entry i at bits [(i+1)*8-1 : i*8]; R=b0, W=b1, X=b2, A=b4:3, L=b7
- o_rsp_valid  out  1  result available
- i_rsp_ready  in  1  consumer takes the result
- o_rsp_code  out  4  `NO_E / `E_ILLEGAL_INSTR / `E_LOAD_ACCESS_FAULT / `E_STORE_ACCESS_FAULT
- o_rsp_hit  out  1  an entry matched
- o_rsp_idx  out  6  index of the matching entry (0 if no hit)

Behaviour:
- Reset values: state IDLE, index 0, o_req_ready=1, o_rsp_valid=0, o_rsp_code=`NO_E, o_rsp_hit=0, o_rsp_idx=0.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: o_req_ready=1. On i_req_valid, latch addr/type/priv, set index=0, go to SCAN. Ready is low in SCAN and RESP.
  - SCAN: evaluate entry[index] combinationally against the live config inputs.
    - On a match, or when index==ENABLED_PMP_REGISTERS-1, register the result and go to RESP.
    - Otherwise increment index.
  - RESP: hold o_rsp_valid and all outputs stable until i_rsp_ready. On the handshake, go to IDLE with o_rsp_valid=0.
- Latency:
  - First entry is evaluated in the cycle after acceptance.
  - A match on entry k asserts o_rsp_valid k+2 cycles after the accept edge.
  - Worst case is ENABLED_PMP_REGISTERS+1 cycles.
- Matching (all compares unsigned, AW bits):
  - A=00 OFF: no match.
  - A=01 TOR: match when (prev<<2) <= addr < (cur<<2), where prev = pmpaddr[index-1], or 0 when index=0. If prev >= cur, no match.
  - A=10 NA4: match when (cur<<2) <= addr < (cur<<2)+4.
  - A=11 NAPOT:
    - t = number of trailing ones in cur.
    - base = cur with its low t+1 bits cleared, shifted left by 2.
    - size = 1<<(t+3).
    - Match when base <= addr < base+size. All-ones cur gives t=AW and matches every address.
  - Shifted values are truncated to AW bits.
- Permission check for the request type: fetch uses X, load uses R, store uses W.
  - Failure codes: fetch gives `E_ILLEGAL_INSTR, load gives `E_LOAD_ACCESS_FAULT, store gives `E_STORE_ACCESS_FAULT.
  - Match with priv=M(11) and L=0: `NO_E.
  - Match with priv=M and L=1, or priv!=M: apply the permission check.
  - No match with priv=M: `NO_E. No match with priv!=M: the failure code for the type.
- Simultaneous and abort events:
  - i_cfg_dirty during SCAN: index resets to 0 next cycle; no response is produced from the current cycle's evaluation.
  - i_cfg_dirty in RESP: ignored, because the result was already decided.
  - i_flush in SCAN or RESP: go to IDLE next cycle and drop o_rsp_valid. i_flush has priority over a match, over i_cfg_dirty and over the response handshake.
  - i_flush in IDLE: the request in that same cycle is not accepted.
- Reset mid-operation: all state and outputs return to their reset values immediately (asynchronous); an in-flight request is lost.
- Back-to-back operation: the RESP handshake returns to IDLE. The next request is accepted one cycle later; there is no same-cycle turnaround.

Decomposition:
- Shared package/defines (riscv_defines.vh):
  - PMP cfg field positions.
  - A-field encodings PMP_OFF/TOR/NA4/NAPOT.
  - Request-type encodings REQ_FETCH/LOAD/STORE.
  - FSM state encodings.
  - Existing exception codes.
- One sub-module, pmp_entry_match: combinational, takes (addr, cur, prev, cfg) and produces (hit, perm_ok for the type). It is instantiated once and fed by the index mux.
- The sequencer holds the FSM, the index counter, the request latch and the response registers.

Test Plan:
- Load at addr 0x1000, priv=U, entry0 TOR pmpaddr=0x800 cfg=0x09 (R, TOR) -> hit idx0, `NO_E, o_rsp_valid 2 cycles after accept.
- Store to 0x2004, priv=S, entry3 NA4 pmpaddr=0x801 cfg=0x11 (R only), entries 0-2 OFF -> hit idx3, `E_STORE_ACCESS_FAULT, valid 5 cycles after accept.
- Fetch at 0x4000, priv=M, entry1 NAPOT pmpaddr=0x17FF cfg=0x98 (L=1, X=0) -> hit idx1, `E_ILLEGAL_INSTR; repeat with L=0 -> `NO_E.
- Load at 0x9000, priv=U, all 12 entries OFF -> o_rsp_hit=0, `E_LOAD_ACCESS_FAULT after 13 cycles; same request with priv=M -> `NO_E.
- i_cfg_dirty pulsed at scan index 5, then i_flush during a second scan -> first scan restarts at 0 with its latency extended; second returns to IDLE with no o_rsp_valid.
- Hold i_rsp_ready=0 for 4 cycles in RESP, then assert i_rst mid-SCAN -> outputs stable while held; after reset all outputs are 0 and o_req_ready=1 immediately.
